// File: rtl/clk_enable_gen.sv
// Divided waveforms and clock-enable pulses for NUM_CH channels from one clock.
// Latency: outputs are registered; a configupdate at edge t gives the first HIGH after edge t+1+initial.
// Backpressure: none; cfg writes and updates are accepted every cycle, and clkena gates outputs one cycle later.
module clk_enable_gen #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 8,
    parameter int CH_W        = 2,
    parameter int DEF_HIGH    = 1,
    parameter int DEF_LOW     = 1,
    parameter int DEF_INITIAL = 0
) (
    input  logic              inclk,
    input  logic              areset,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_high,
    input  logic [CNT_W-1:0]  cfg_low,
    input  logic [CNT_W-1:0]  cfg_initial,
    input  logic              configupdate,
    input  logic [NUM_CH-1:0] clkena,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] clk_ce,
    output logic              locked
);

    localparam logic [1:0] ST_OFF  = 2'd0;
    localparam logic [1:0] ST_INIT = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;
    localparam logic [1:0] ST_LOW  = 2'd3;

    localparam logic [CNT_W-1:0] DEF_H = CNT_W'(DEF_HIGH);
    localparam logic [CNT_W-1:0] DEF_L = CNT_W'(DEF_LOW);
    localparam logic [CNT_W-1:0] DEF_N = CNT_W'(DEF_INITIAL);
    // A zero default count would underflow the reload, so such a channel starts parked in OFF.
    localparam logic       DEF_OFF = (DEF_HIGH == 0) || (DEF_LOW == 0);
    localparam logic [1:0] ST_RST  = DEF_OFF ? ST_OFF : ST_INIT;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] sh_high_q  [NUM_CH];
    logic [CNT_W-1:0] sh_high_d  [NUM_CH];
    logic [CNT_W-1:0] sh_low_q   [NUM_CH];
    logic [CNT_W-1:0] sh_low_d   [NUM_CH];
    logic [CNT_W-1:0] sh_init_q  [NUM_CH];
    logic [CNT_W-1:0] sh_init_d  [NUM_CH];
    logic [CNT_W-1:0] act_high_q [NUM_CH];
    logic [CNT_W-1:0] act_high_d [NUM_CH];
    logic [CNT_W-1:0] act_low_q  [NUM_CH];
    logic [CNT_W-1:0] act_low_d  [NUM_CH];
    logic [CNT_W-1:0] cnt_q      [NUM_CH];
    logic [CNT_W-1:0] cnt_d      [NUM_CH];
    logic [1:0]       state_q    [NUM_CH];
    logic [1:0]       state_d    [NUM_CH];

    logic [NUM_CH-1:0] started_q, started_d;
    logic [NUM_CH-1:0] clk_out_q, clk_out_d;
    logic [NUM_CH-1:0] clk_ce_q, clk_ce_d;
    logic [NUM_CH-1:0] enter_high;
    logic              locked_q, locked_d;

    // Shadow registers: only the addressed channel is written; out-of-range indices match nothing.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            sh_high_d[i] = sh_high_q[i];
            sh_low_d[i]  = sh_low_q[i];
            sh_init_d[i] = sh_init_q[i];
            if (cfg_wr && (int'(cfg_ch) == i)) begin
                sh_high_d[i] = cfg_high;
                sh_low_d[i]  = cfg_low;
                sh_init_d[i] = cfg_initial;
            end
        end
    end

    // Channel FSMs: configupdate restarts every channel from the pre-write shadow values.
    always_comb begin
        enter_high = '0;
        started_d  = started_q;
        clk_out_d  = '0;
        clk_ce_d   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            act_high_d[i] = act_high_q[i];
            act_low_d[i]  = act_low_q[i];
            state_d[i]    = state_q[i];
            cnt_d[i]      = cnt_q[i];
            if (configupdate) begin
                act_high_d[i] = sh_high_q[i];
                act_low_d[i]  = sh_low_q[i];
                if ((sh_high_q[i] == '0) || (sh_low_q[i] == '0)) begin
                    state_d[i]   = ST_OFF;
                    cnt_d[i]     = '0;
                    started_d[i] = 1'b1;
                end else begin
                    state_d[i]   = ST_INIT;
                    cnt_d[i]     = sh_init_q[i];
                    started_d[i] = 1'b0;
                end
            end else begin
                case (state_q[i])
                    ST_INIT, ST_LOW: begin
                        if (cnt_q[i] == '0) begin
                            state_d[i]    = ST_HIGH;
                            cnt_d[i]      = act_high_q[i] - ONE;
                            enter_high[i] = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] - ONE;
                        end
                    end
                    ST_HIGH: begin
                        if (cnt_q[i] == '0) begin
                            state_d[i] = ST_LOW;
                            cnt_d[i]   = act_low_q[i] - ONE;
                        end else begin
                            cnt_d[i] = cnt_q[i] - ONE;
                        end
                    end
                    default: begin
                        state_d[i] = ST_OFF;
                    end
                endcase
                if (enter_high[i]) begin
                    started_d[i] = 1'b1;
                end
            end
            clk_out_d[i] = (state_d[i] == ST_HIGH) && clkena[i];
            clk_ce_d[i]  = enter_high[i] && clkena[i];
        end
        // Lock follows the registered flags, so it trails the last channel's first HIGH by one cycle.
        locked_d = configupdate ? 1'b0 : (&started_q);
    end

    // State registers; reset restores the defaults into both shadow and active copies.
    always_ff @(posedge inclk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                sh_high_q[i]  <= DEF_H;
                sh_low_q[i]   <= DEF_L;
                sh_init_q[i]  <= DEF_N;
                act_high_q[i] <= DEF_H;
                act_low_q[i]  <= DEF_L;
                cnt_q[i]      <= DEF_OFF ? '0 : DEF_N;
                state_q[i]    <= ST_RST;
            end
            started_q <= {NUM_CH{DEF_OFF}};
            clk_out_q <= '0;
            clk_ce_q  <= '0;
            locked_q  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                sh_high_q[i]  <= sh_high_d[i];
                sh_low_q[i]   <= sh_low_d[i];
                sh_init_q[i]  <= sh_init_d[i];
                act_high_q[i] <= act_high_d[i];
                act_low_q[i]  <= act_low_d[i];
                cnt_q[i]      <= cnt_d[i];
                state_q[i]    <= state_d[i];
            end
            started_q <= started_d;
            clk_out_q <= clk_out_d;
            clk_ce_q  <= clk_ce_d;
            locked_q  <= locked_d;
        end
    end

    assign clk_out = clk_out_q;
    assign clk_ce  = clk_ce_q;
    assign locked  = locked_q;

endmodule

// File: tb/tb_clk_enable_gen.sv
// Bench for clk_enable_gen with three channels and a two-bit channel index.
// Expected outputs per edge come from a closed-form phase formula and are queued by the stimulus.
// A monitor pops one entry per edge and compares clk_out, clk_ce and locked.
module tb_clk_enable_gen;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 8;
    localparam int CH_W   = 2;

    logic              inclk = 1'b0;
    logic              areset = 1'b1;
    logic              cfg_wr = 1'b0;
    logic [CH_W-1:0]   cfg_ch = '0;
    logic [CNT_W-1:0]  cfg_high = '0;
    logic [CNT_W-1:0]  cfg_low = '0;
    logic [CNT_W-1:0]  cfg_initial = '0;
    logic              configupdate = 1'b0;
    logic [NUM_CH-1:0] clkena = '1;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] clk_ce;
    logic              locked;

    clk_enable_gen #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .CH_W(CH_W),
        .DEF_HIGH(1), .DEF_LOW(1), .DEF_INITIAL(0)
    ) dut (
        .inclk(inclk), .areset(areset), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
        .cfg_high(cfg_high), .cfg_low(cfg_low), .cfg_initial(cfg_initial),
        .configupdate(configupdate), .clkena(clkena),
        .clk_out(clk_out), .clk_ce(clk_ce), .locked(locked)
    );

    always #5 inclk = ~inclk;

    typedef struct packed {
        logic [NUM_CH-1:0] out;
        logic [NUM_CH-1:0] ce;
        logic              lk;
    } exp_t;

    exp_t q[$];
    exp_t m;
    int   checks = 0;
    int   failures = 0;
    int   cyc_no = 0;

    // Bench-side model: active and shadow counts, and edges elapsed since restart.
    int ah[NUM_CH], al[NUM_CH], an[NUM_CH];
    int sh[NUM_CH], sl[NUM_CH], sn[NUM_CH];
    int k = 0;

    task automatic cyc(input logic rst, input logic cu, input logic wr, input int ch,
                       input int h, input int l, input int n, input logic [NUM_CH-1:0] en);
        exp_t e;
        int   p;
        int   per;
        logic all_st;
        @(negedge inclk);
        areset       = rst;
        configupdate = cu;
        cfg_wr       = wr;
        cfg_ch       = CH_W'(ch);
        cfg_high     = CNT_W'(h);
        cfg_low      = CNT_W'(l);
        cfg_initial  = CNT_W'(n);
        clkena       = en;
        e = '0;
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                ah[c] = 1; al[c] = 1; an[c] = 0;
                sh[c] = 1; sl[c] = 1; sn[c] = 0;
            end
            k = 0;
        end else if (cu) begin
            for (int c = 0; c < NUM_CH; c++) begin
                ah[c] = sh[c]; al[c] = sl[c]; an[c] = sn[c];
            end
            k = 0;
        end else begin
            k++;
            all_st = 1'b1;
            for (int c = 0; c < NUM_CH; c++) begin
                if (ah[c] == 0 || al[c] == 0) continue;
                p   = k - 1 - an[c];
                per = ah[c] + al[c];
                if (p >= 0 && (p % per) < ah[c]) e.out[c] = en[c];
                if (p >= 0 && (p % per) == 0)    e.ce[c]  = en[c];
                if (k < an[c] + 2) all_st = 1'b0;
            end
            e.lk = all_st;
        end
        if (!rst && wr && ch < NUM_CH) begin
            sh[ch] = h; sl[ch] = l; sn[ch] = n;
        end
        q.push_back(e);
        @(posedge inclk);
    endtask

    task automatic run(input int nc, input logic [NUM_CH-1:0] en);
        for (int i = 0; i < nc; i++) cyc(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, en);
    endtask

    task automatic wr_ch(input int ch, input int h, input int l, input int n);
        cyc(1'b0, 1'b0, 1'b1, ch, h, l, n, '1);
    endtask

    task automatic update();
        cyc(1'b0, 1'b1, 1'b0, 0, 0, 0, 0, '1);
    endtask

    // Monitor: one queued expectation per edge, sampled shortly after the edge.
    always @(posedge inclk) begin
        #1;
        cyc_no++;
        if (q.size() > 0) begin
            m = q.pop_front();
            checks++;
            if (clk_out !== m.out) begin
                failures++;
                $display("FAIL clk_out cycle=%0d got=%b want=%b", cyc_no, clk_out, m.out);
            end
            checks++;
            if (clk_ce !== m.ce) begin
                failures++;
                $display("FAIL clk_ce cycle=%0d got=%b want=%b", cyc_no, clk_ce, m.ce);
            end
            checks++;
            if (locked !== m.lk) begin
                failures++;
                $display("FAIL locked cycle=%0d got=%b want=%b", cyc_no, locked, m.lk);
            end
        end
    end

    initial begin
        // Reset, then release with defaults: divide-by-2 on every channel.
        cyc(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, '1);
        cyc(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, '1);
        run(8, '1);

        // ch0 3/2/0 and ch1 3/2/4: ch1 starts four cycles after ch0.
        wr_ch(0, 3, 2, 0);
        wr_ch(1, 3, 2, 4);
        update();
        run(20, '1);

        // ch2 low=0 parks it in OFF; lock depends only on ch0/ch1.
        wr_ch(2, 1, 0, 0);
        update();
        run(12, '1);

        // Gate ch0 for seven cycles; phase must continue underneath.
        run(3, '1);
        run(7, 3'b110);
        run(10, '1);

        // Write and update in the same cycle: the update uses old ch1 values.
        cyc(1'b0, 1'b1, 1'b1, 1, 2, 1, 1, '1);
        run(10, '1);
        update();
        run(10, '1);

        // Index 3 does not exist with three channels; the write must be ignored.
        wr_ch(3, 1, 1, 0);
        update();
        run(10, '1);

        // Reprogram ch0 then reset mid-period.
        wr_ch(0, 4, 4, 0);
        update();
        run(6, '1);
        #3;
        areset = 1'b1;
        #1;
        checks++;
        if (clk_out !== '0 || clk_ce !== '0 || locked !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got=%b/%b/%b want=000/000/0", clk_out, clk_ce, locked);
        end
        cyc(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, '1);
        cyc(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, '1);
        run(8, '1);

        @(posedge inclk);
        #2;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain got=%0d want=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
